// File: rtl/montgomery_mul.sv
// Bit-serial Montgomery multiplier: o_m = a*b*2^-WIDTH mod n, one a-bit per clock,
// WIDTH+1 cycles from start sample to the o_finished pulse.
module montgomery_mul #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_m,
  output logic             o_finished,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int ACC_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [ACC_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   om_q, om_d;
  logic               fin_q, fin_d;
  logic               busy_q;

  logic               a_bit;
  logic [ACC_W-1:0]   b_ext, n_ext;
  logic [ACC_W-1:0]   t_add, t_red, m_sub;

  // Iteration datapath: the WIDTH+2 accumulator holds m + b + n (< 4n) without loss.
  always_comb begin
    a_bit = a_q[cnt_q[IDX_W-1:0]];
    b_ext = {2'b00, b_q};
    n_ext = {2'b00, n_q};
    t_add = a_bit ? (m_q + b_ext) : m_q;
    t_red = t_add[0] ? (t_add + n_ext) : t_add;
    m_sub = m_q - n_ext;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    om_d    = om_q;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          n_d     = i_n;
          m_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        m_d   = t_red >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        om_d    = (m_q >= n_ext) ? m_sub[WIDTH-1:0] : m_q[WIDTH-1:0];
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result state; reset can land mid-operation and discards it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      cnt_q   <= '0;
      om_q    <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      om_q    <= om_d;
      fin_q   <= fin_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Latched operands are only meaningful after a start, so they carry no reset.
  always_ff @(posedge i_clk) begin
    a_q <= a_d;
    b_q <= b_d;
    n_q <= n_d;
  end

  assign o_m        = om_q;
  assign o_finished = fin_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_montgomery_mul.sv
// Scoreboard bench for montgomery_mul at WIDTH=8 and WIDTH=256.
module tb_montgomery_mul;

  localparam int W8   = 8;
  localparam int W256 = 256;

  typedef struct {
    logic [255:0] val;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st8;
  logic [7:0]   a8, b8, n8, m8;
  logic         fin8, busy8;
  logic         st256;
  logic [255:0] a256, b256, n256, m256;
  logic         fin256, busy256;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp8[$];
  exp_t exp256[$];
  exp_t e8, e256;

  montgomery_mul #(.WIDTH(W8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st8),
    .i_a(a8), .i_b(b8), .i_n(n8),
    .o_m(m8), .o_finished(fin8), .o_busy(busy8)
  );

  montgomery_mul #(.WIDTH(W256)) dut256 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st256),
    .i_a(a256), .i_b(b256), .i_n(n256),
    .o_m(m256), .o_finished(fin256), .o_busy(busy256)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a*b*2^-w mod n, using 2^-1 mod n = (n+1)/2 for odd n.
  function automatic longint unsigned mref(input longint unsigned a, input longint unsigned b,
                                           input longint unsigned n, input int w);
    longint unsigned inv2, r;
    inv2 = (n + 1) / 2;
    r = (a * b) % n;
    for (int i = 0; i < w; i++) r = (r * inv2) % n;
    return r;
  endfunction

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void fail_evt(input string name, input int expc);
    n_cmp++;
    n_err++;
    $display("FAIL %s: at cycle %0d, expected cycle %0d", name, cyc, expc);
  endfunction

  // Monitors: pop and compare whenever a DUT flags a result; expired entries are failures.
  always @(negedge clk) begin
    if (exp8.size() > 0 && exp8[0].cyc < cyc) begin
      fail_evt("fin8_missing", exp8[0].cyc);
      void'(exp8.pop_front());
    end
    if (fin8) begin
      if (exp8.size() == 0) fail_evt("fin8_unexpected", -1);
      else begin
        e8 = exp8.pop_front();
        chk("m8_value", {248'b0, m8}, e8.val);
        chk("fin8_cycle", 256'(cyc), 256'(e8.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (exp256.size() > 0 && exp256[0].cyc < cyc) begin
      fail_evt("fin256_missing", exp256[0].cyc);
      void'(exp256.pop_front());
    end
    if (fin256) begin
      if (exp256.size() == 0) fail_evt("fin256_unexpected", -1);
      else begin
        e256 = exp256.pop_front();
        chk("m256_value", m256, e256.val);
        chk("fin256_cycle", 256'(cyc), 256'(e256.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge where o_finished is expected high,
  // so an immediate second call issues a back-to-back start.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                     input bit noise, input bit chk_busy);
    exp_t e;
    a8 = a; b8 = b; n8 = n; st8 = 1'b1;
    e.val = 256'(mref(64'(a), 64'(b), 64'(n), W8));
    e.cyc = cyc + 1 + W8 + 1;
    exp8.push_back(e);
    @(negedge clk);
    st8 = 1'b0;
    if (chk_busy) chk("busy8_start", {255'b0, busy8}, 256'd1);
    for (int i = 0; i <= W8; i++) begin
      if (noise) begin
        st8 = 1'($urandom);
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        n8  = 8'($urandom);
      end
      if (chk_busy && i == W8) chk("busy8_final", {255'b0, busy8}, 256'd1);
      @(negedge clk);
    end
    st8 = 1'b0;
    if (chk_busy) chk("busy8_done", {255'b0, busy8}, 256'd0);
  endtask

  task automatic go256(input longint unsigned a, input longint unsigned b, input longint unsigned n);
    exp_t e;
    a256 = 256'(a); b256 = 256'(b); n256 = 256'(n); st256 = 1'b1;
    e.val = 256'(mref(a, b, n, W256));
    e.cyc = cyc + 1 + W256 + 1;
    exp256.push_back(e);
    @(negedge clk);
    st256 = 1'b0;
    chk("busy256_start", {255'b0, busy256}, 256'd1);
    repeat (W256 + 1) @(negedge clk);
    chk("busy256_done", {255'b0, busy256}, 256'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]      rn, ra, rb;
    longint unsigned ln, la, lb;
    rst_n = 1'b0;
    st8 = 1'b0; a8 = '0; b8 = '0; n8 = '0;
    st256 = 1'b0; a256 = '0; b256 = '0; n256 = '0;
    repeat (3) @(negedge clk);
    chk("rst_m8", {248'b0, m8}, 256'd0);
    chk("rst_fin8", {255'b0, fin8}, 256'd0);
    chk("rst_busy8", {255'b0, busy8}, 256'd0);
    chk("rst_m256", m256, 256'd0);
    chk("rst_fin256", {255'b0, fin256}, 256'd0);
    chk("rst_busy256", {255'b0, busy256}, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    go8(8'd3, 8'd5, 8'd13, 1'b0, 1'b1);
    go8(8'd1, 8'd1, 8'd13, 1'b0, 1'b1);
    go8(8'd0, 8'd12, 8'd13, 1'b0, 1'b1);
    go8(8'd12, 8'd12, 8'd13, 1'b0, 1'b1);
    go8(8'd254, 8'd254, 8'd255, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    go8(8'd3, 8'd5, 8'd13, 1'b1, 1'b0);
    go8(8'd3, 8'd5, 8'd13, 1'b0, 1'b1);
    go8(8'd3, 8'd5, 8'd13, 1'b0, 1'b1);

    for (int t = 0; t < 30; t++) begin
      rn = 8'($urandom_range(1, 127) * 2 + 1);
      ra = 8'($urandom_range(0, int'(rn) - 1));
      rb = 8'($urandom_range(0, int'(rn) - 1));
      go8(ra, rb, rn, 1'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset in the middle of an operation, after iteration 4.
    go8(8'd3, 8'd5, 8'd13, 1'b0, 1'b0);
    a8 = 8'd7; b8 = 8'd9; n8 = 8'd13; st8 = 1'b1;
    e8.val = 256'(mref(64'd7, 64'd9, 64'd13, W8));
    e8.cyc = cyc + 1 + W8 + 1;
    exp8.push_back(e8);
    @(negedge clk);
    st8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    void'(exp8.pop_back());
    #1;
    chk("midrst_m8", {248'b0, m8}, 256'd0);
    chk("midrst_busy8", {255'b0, busy8}, 256'd0);
    chk("midrst_fin8", {255'b0, fin8}, 256'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go8(8'd1, 8'd1, 8'd13, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    go256(64'd2, 64'd1, 64'd1000000007);
    for (int t = 0; t < 5; t++) begin
      ln = 64'($urandom) | 64'd1;
      if (ln < 64'd3) ln = 64'd3;
      la = 64'($urandom) % ln;
      lb = 64'($urandom) % ln;
      go256(la, lb, ln);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
